// File: rtl/neural_pkt_pkg.sv
// rtl/neural_pkt_pkg.sv - shared widths, packet field offsets and parity helper for the packet framer
// Purpose: default parameter values, LSB offsets of each packet field
//          ({ts, channel, data, seq, drop_flag, parity}, MSB first) and
//          an even-parity reduction usable for any packet width up to PARITY_MAX_W.
package neural_pkt_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_CH_ID_WIDTH = 4;
  localparam int DEF_TS_WIDTH    = 32;
  localparam int DEF_SEQ_WIDTH   = 10;
  localparam int DEF_FIFO_DEPTH  = 8;

  // Upper bound on packet width accepted by even_parity; narrower words are zero-extended.
  localparam int PARITY_MAX_W = 256;

  // Bit 0 is parity, bit 1 is drop_flag, so seq always starts at bit 2.
  function automatic int seq_lsb();
    return 2;
  endfunction

  function automatic int data_lsb(input int seq_w);
    return seq_lsb() + seq_w;
  endfunction

  function automatic int ch_lsb(input int seq_w, input int data_w);
    return data_lsb(seq_w) + data_w;
  endfunction

  function automatic int ts_lsb(input int seq_w, input int data_w, input int ch_w);
    return ch_lsb(seq_w, data_w) + ch_w;
  endfunction

  // Returns the bit that makes the XOR of {v, bit} zero.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/neural_pkt_if.sv
// rtl/neural_pkt_if.sv - valid/ready packet stream between framer and link serializer
// Ports: pkt_data (framed packet), pkt_valid (head present), pkt_ready (sink accepts).
// master = framer side, slave = serializer side.
interface neural_pkt_if #(
  parameter int WIDTH = 64
) ();

  logic [WIDTH-1:0] pkt_data;
  logic             pkt_valid;
  logic             pkt_ready;

  modport master (output pkt_data, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, input pkt_valid, output pkt_ready);

endinterface

// File: rtl/neural_pkt_fifo.sv
// rtl/neural_pkt_fifo.sv - synchronous packet FIFO with registered head
// Ports: clk, rst (sync, active-high), push/push_data, pop,
//        head_data/head_valid (registered head), full, level (occupancy).
// A push into an empty FIFO appears on the head one edge later than the write;
// push and pop in the same cycle are accepted even when full.
module neural_pkt_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [LVL_W-1:0] remaining;
  logic             push_ok, pop_ok;

  assign full       = (count_q == LVL_W'(DEPTH));
  assign level      = count_q;
  assign head_data  = data_q;
  assign head_valid = valid_q;

  always_comb begin
    pop_ok    = pop && valid_q;
    push_ok   = push && (!full || pop_ok);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    remaining = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      count_d         = count_d + LVL_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      count_d   = count_d - LVL_W'(1);
      remaining = count_q - LVL_W'(1);
    end
    // The head only shows entries already in memory before this edge, so the
    // next head is always read from mem_q and never bypassed from push_data.
    valid_d = (remaining != '0);
    data_d  = valid_d ? mem_q[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/neural_packet_framer_buf.sv
// rtl/neural_packet_framer_buf.sv - stamps acquisition samples into packets and buffers them for the serializer
// Ports: sensor_clk, sensor_rst (sync, active-high), ts_clear, ch_enable,
//        acq_data/acq_channel/acq_valid (non-stallable sample input),
//        pkt_if (master packet stream), fifo_level, drop_count (saturating), overflow (sticky).
module neural_packet_framer_buf
  import neural_pkt_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int CH_ID_WIDTH  = DEF_CH_ID_WIDTH,
  parameter  int TS_WIDTH     = DEF_TS_WIDTH,
  parameter  int SEQ_WIDTH    = DEF_SEQ_WIDTH,
  parameter  int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  localparam int NUM_CH       = 1 << CH_ID_WIDTH,
  localparam int PACKET_WIDTH = TS_WIDTH + CH_ID_WIDTH + DATA_WIDTH + SEQ_WIDTH + 2,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   sensor_clk,
  input  logic                   sensor_rst,
  input  logic                   ts_clear,
  input  logic [NUM_CH-1:0]      ch_enable,
  input  logic [DATA_WIDTH-1:0]  acq_data,
  input  logic [CH_ID_WIDTH-1:0] acq_channel,
  input  logic                   acq_valid,
  neural_pkt_if.master           pkt_if,
  output logic [LVL_W-1:0]       fifo_level,
  output logic [15:0]            drop_count,
  output logic                   overflow
);

  localparam int SEQ_LSB  = seq_lsb();
  localparam int DATA_LSB = data_lsb(SEQ_WIDTH);
  localparam int CH_LSB   = ch_lsb(SEQ_WIDTH, DATA_WIDTH);
  localparam int TS_LSB   = ts_lsb(SEQ_WIDTH, DATA_WIDTH, CH_ID_WIDTH);

  logic [TS_WIDTH-1:0]     ts_q, ts_d;
  logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    pend_drop_q, pend_drop_d;
  logic [PACKET_WIDTH-1:0] pkt_word;
  logic                    full, pop, enabled, accept, drop;

  assign pop     = pkt_if.pkt_valid && pkt_if.pkt_ready;
  assign enabled = acq_valid && ch_enable[acq_channel];
  assign accept  = enabled && (!full || pop);
  assign drop    = enabled && full && !pop;

  always_comb begin
    pkt_word                            = '0;
    pkt_word[TS_LSB +: TS_WIDTH]        = ts_q;
    pkt_word[CH_LSB +: CH_ID_WIDTH]     = acq_channel;
    pkt_word[DATA_LSB +: DATA_WIDTH]    = acq_data;
    pkt_word[SEQ_LSB +: SEQ_WIDTH]      = seq_q;
    pkt_word[1]                         = pend_drop_q;
    pkt_word[0]                         = even_parity(PARITY_MAX_W'(pkt_word));
  end

  always_comb begin
    ts_d        = ts_clear ? '0 : ts_q + TS_WIDTH'(1);
    seq_d       = seq_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    pend_drop_d = pend_drop_q;
    if (accept) begin
      seq_d       = seq_q + SEQ_WIDTH'(1);
      pend_drop_d = 1'b0;
    end
    if (drop) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      overflow_d  = 1'b1;
      pend_drop_d = 1'b1;
    end
  end

  always_ff @(posedge sensor_clk) begin
    if (sensor_rst) begin
      ts_q        <= '0;
      seq_q       <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      pend_drop_q <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      seq_q       <= seq_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      pend_drop_q <= pend_drop_d;
    end
  end

  neural_pkt_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (sensor_clk),
    .rst        (sensor_rst),
    .push       (accept),
    .push_data  (pkt_word),
    .pop        (pop),
    .head_data  (pkt_if.pkt_data),
    .head_valid (pkt_if.pkt_valid),
    .full       (full),
    .level      (fifo_level)
  );

  assign drop_count = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_neural_packet_framer_buf.sv
// tb/tb_neural_packet_framer_buf.sv - directed self-checking bench for neural_packet_framer_buf
module tb_neural_packet_framer_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ts_clear = 1'b0;
  logic [15:0] ch_enable = 16'hFFFF;
  logic [15:0] acq_data = '0;
  logic [3:0]  acq_channel = '0;
  logic        acq_valid = 1'b0;
  logic [3:0]  level;
  logic [15:0] drop_count;
  logic        overflow;
  logic [3:0]  level_s;
  logic [15:0] drop_s;
  logic        ovf_s;

  int checks = 0;
  int failures = 0;

  logic [63:0] mon_q [$];
  logic [35:0] mon_s [$];

  always #5 clk = ~clk;

  neural_pkt_if #(.WIDTH(64)) pif ();
  neural_pkt_if #(.WIDTH(36)) pif_s ();

  neural_packet_framer_buf dut (
    .sensor_clk  (clk),
    .sensor_rst  (rst),
    .ts_clear    (ts_clear),
    .ch_enable   (ch_enable),
    .acq_data    (acq_data),
    .acq_channel (acq_channel),
    .acq_valid   (acq_valid),
    .pkt_if      (pif),
    .fifo_level  (level),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  neural_packet_framer_buf #(.TS_WIDTH(4)) dut_s (
    .sensor_clk  (clk),
    .sensor_rst  (rst),
    .ts_clear    (ts_clear),
    .ch_enable   (ch_enable),
    .acq_data    (acq_data),
    .acq_channel (acq_channel),
    .acq_valid   (acq_valid),
    .pkt_if      (pif_s),
    .fifo_level  (level_s),
    .drop_count  (drop_s),
    .overflow    (ovf_s)
  );

  always @(negedge clk) begin
    if (pif.pkt_valid && pif.pkt_ready) mon_q.push_back(pif.pkt_data);
    if (pif_s.pkt_valid && pif_s.pkt_ready) mon_s.push_back(pif_s.pkt_data);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ch, input logic [15:0] d);
    acq_valid   = 1'b1;
    acq_channel = ch;
    acq_data    = d;
    tick();
    acq_valid   = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    acq_valid = 1'b0;
    ts_clear = 1'b0;
    ch_enable = 16'hFFFF;
    pif.pkt_ready = 1'b0;
    tick();
    rst = 1'b0;
    mon_q.delete();
    mon_s.delete();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    pif.pkt_ready = 1'b1;
    while ((pif.pkt_valid || level != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (pif.pkt_valid || level != 0) begin
      failures++;
      $display("FAIL drain_timeout: level=%0d valid=%0b after %0d cycles, required empty", level, pif.pkt_valid, n);
    end
  endtask

  task automatic test_reset_and_latency;
    logic [62:0] body;
    logic [63:0] exp;
    do_reset();
    pif.pkt_ready = 1'b1;
    checks++; if (pif.pkt_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", pif.pkt_valid); end
    checks++; if (pif.pkt_data !== 64'd0) begin failures++; $display("FAIL rst_data: got %h want 0", pif.pkt_data); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
    ts_clear = 1'b1;
    tick();
    ts_clear = 1'b0;
    repeat (5) tick();
    send(4'h3, 16'hABCD);
    checks++; if (pif.pkt_valid !== 1'b0) begin failures++; $display("FAIL t1_latency_early: valid=%0b want 0", pif.pkt_valid); end
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL t1_level: got %0d want 1", level); end
    tick();
    body = {32'd5, 4'h3, 16'hABCD, 10'd0, 1'b0};
    exp = {body, ^body};
    checks++; if (pif.pkt_valid !== 1'b1) begin failures++; $display("FAIL t1_valid: got %0b want 1", pif.pkt_valid); end
    checks++; if (pif.pkt_data !== exp) begin failures++; $display("FAIL t1_packet: got %h want %h", pif.pkt_data, exp); end
    checks++; if ((^pif.pkt_data) !== 1'b0) begin failures++; $display("FAIL t1_parity: xor=%0b want 0", ^pif.pkt_data); end
    tick();
    checks++; if (pif.pkt_valid !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL t1_popped: valid=%0b level=%0d want 0/0", pif.pkt_valid, level); end
  endtask

  task automatic test_overflow;
    logic [63:0] held, p;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 9; i++) send(4'h0, 16'(i));
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL t2_level: got %0d want 8", level); end
    checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL t2_drop: got %0d want 1", drop_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL t2_overflow: got %0b want 1", overflow); end
    held = pif.pkt_data;
    tick();
    tick();
    checks++; if (pif.pkt_data !== held || held[27:12] !== 16'd0) begin failures++; $display("FAIL t2_hold: got %h held %h want data 0 stable", pif.pkt_data, held); end
    drain(40);
    checks++; if (mon_q.size() != 8) begin failures++; $display("FAIL t2_count: got %0d want 8", mon_q.size()); end
    for (int i = 0; i < mon_q.size(); i++) begin
      p = mon_q[i];
      if (p[11:2] !== 10'(i) || p[27:12] !== 16'(i) || p[1] !== 1'b0 || (^p) !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL t2_seq: %0d bad packets want 0", bad); end
    send(4'h5, 16'h55AA);
    drain(10);
    send(4'h5, 16'h1234);
    drain(10);
    checks++; if (mon_q.size() != 10) begin failures++; $display("FAIL t2_count2: got %0d want 10", mon_q.size()); end
    else begin
      p = mon_q[8];
      checks++; if (p[11:2] !== 10'd8 || p[1] !== 1'b1 || p[27:12] !== 16'h55AA || p[31:28] !== 4'h5) begin failures++; $display("FAIL t2_dropflag: got %h want seq 8 flag 1 data 55aa ch 5", p); end
      p = mon_q[9];
      checks++; if (p[11:2] !== 10'd9 || p[1] !== 1'b0) begin failures++; $display("FAIL t2_flagclear: got seq %0d flag %0b want 9/0", p[11:2], p[1]); end
    end
    checks++; if (drop_count !== 16'd1 || overflow !== 1'b1) begin failures++; $display("FAIL t2_sticky: drop=%0d ovf=%0b want 1/1", drop_count, overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [63:0] p;
    do_reset();
    for (int i = 0; i < 8; i++) send(4'h0, 16'h100 + 16'(i));
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL t3_full: got %0d want 8", level); end
    pif.pkt_ready = 1'b1;
    send(4'h0, 16'h01FF);
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL t3_level: got %0d want 8", level); end
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL t3_nodrop: drop=%0d ovf=%0b want 0/0", drop_count, overflow); end
    drain(40);
    checks++; if (mon_q.size() != 9) begin failures++; $display("FAIL t3_count: got %0d want 9", mon_q.size()); end
    else begin
      p = mon_q[0];
      checks++; if (p[27:12] !== 16'h0100 || p[11:2] !== 10'd0) begin failures++; $display("FAIL t3_first: got %h want data 0100 seq 0", p); end
      p = mon_q[8];
      checks++; if (p[27:12] !== 16'h01FF || p[11:2] !== 10'd8 || p[1] !== 1'b0) begin failures++; $display("FAIL t3_last: got %h want data 01ff seq 8", p); end
    end
  endtask

  task automatic test_channel_mask;
    logic [63:0] p;
    do_reset();
    ch_enable = 16'hFFFD;
    send(4'h1, 16'hDEAD);
    tick();
    tick();
    checks++; if (level !== 4'd0 || pif.pkt_valid !== 1'b0) begin failures++; $display("FAIL t4_discard: level=%0d valid=%0b want 0/0", level, pif.pkt_valid); end
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL t4_drop: drop=%0d ovf=%0b want 0/0", drop_count, overflow); end
    send(4'h0, 16'h0F0F);
    drain(10);
    ch_enable = 16'hFFFF;
    checks++; if (mon_q.size() != 1) begin failures++; $display("FAIL t4_count: got %0d want 1", mon_q.size()); end
    else begin
      p = mon_q[0];
      checks++; if (p[11:2] !== 10'd0 || p[27:12] !== 16'h0F0F || p[31:28] !== 4'h0) begin failures++; $display("FAIL t4_seq: got %h want seq 0 data 0f0f", p); end
    end
  endtask

  task automatic test_wrap;
    logic [35:0] s;
    logic [63:0] p;
    int bad = 0;
    do_reset();
    pif.pkt_ready = 1'b1;
    ts_clear = 1'b1;
    tick();
    ts_clear = 1'b0;
    repeat (14) tick();
    for (int i = 0; i < 4; i++) send(4'h0, 16'(i));
    drain(20);
    repeat (4) tick();
    checks++; if (mon_s.size() != 4) begin failures++; $display("FAIL t5_small_count: got %0d want 4", mon_s.size()); end
    else begin
      s = mon_s[1];
      checks++; if (s[35:32] !== 4'd15) begin failures++; $display("FAIL t5_ts_max: got %0d want 15", s[35:32]); end
      s = mon_s[2];
      checks++; if (s[35:32] !== 4'd0) begin failures++; $display("FAIL t5_ts_wrap: got %0d want 0", s[35:32]); end
      s = mon_s[3];
      checks++; if (s[35:32] !== 4'd1 || (^s) !== 1'b0) begin failures++; $display("FAIL t5_ts_after: got %h want ts 1 even parity", s); end
    end
    checks++; if (level_s !== 4'd0 || drop_s !== 16'd0 || ovf_s !== 1'b0) begin failures++; $display("FAIL t5_small_state: level=%0d drop=%0d ovf=%0b want 0", level_s, drop_s, ovf_s); end
    checks++; if (mon_q.size() != 4 || mon_q[0][63:32] !== 32'd14) begin failures++; $display("FAIL t5_main_ts: count %0d want 4 with ts 14", mon_q.size()); end

    do_reset();
    pif.pkt_ready = 1'b1;
    for (int i = 0; i < 1026; i++) send(4'h0, 16'(i));
    drain(20);
    checks++; if (mon_q.size() != 1026) begin failures++; $display("FAIL t5_seq_count: got %0d want 1026", mon_q.size()); end
    else begin
      for (int i = 0; i < 1026; i++) begin
        p = mon_q[i];
        if (p[11:2] !== 10'(i % 1024) || p[27:12] !== 16'(i)) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL t5_seq_all: %0d bad packets want 0", bad); end
      p = mon_q[1024];
      checks++; if (p[11:2] !== 10'd0) begin failures++; $display("FAIL t5_seq_wrap: got %0d want 0", p[11:2]); end
    end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL t5_nodrop: got %0d want 0", drop_count); end
  endtask

  task automatic test_mid_reset;
    logic [63:0] p;
    do_reset();
    for (int i = 0; i < 9; i++) send(4'h0, 16'(i));
    pif.pkt_ready = 1'b1;
    repeat (3) tick();
    pif.pkt_ready = 1'b0;
    checks++; if (level !== 4'd5 || drop_count !== 16'd1) begin failures++; $display("FAIL t6_pre: level=%0d drop=%0d want 5/1", level, drop_count); end
    rst = 1'b1;
    tick();
    checks++; if (pif.pkt_valid !== 1'b0 || pif.pkt_data !== 64'd0) begin failures++; $display("FAIL t6_out: valid=%0b data=%h want 0/0", pif.pkt_valid, pif.pkt_data); end
    checks++; if (level !== 4'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL t6_state: level=%0d drop=%0d ovf=%0b want 0", level, drop_count, overflow); end
    rst = 1'b0;
    mon_q.delete();
    send(4'h3, 16'h7777);
    drain(10);
    checks++; if (mon_q.size() != 1) begin failures++; $display("FAIL t6_count: got %0d want 1", mon_q.size()); end
    else begin
      p = mon_q[0];
      checks++; if (p[11:2] !== 10'd0 || p[1] !== 1'b0 || p[27:12] !== 16'h7777) begin failures++; $display("FAIL t6_seq: got %h want seq 0 flag 0 data 7777", p); end
    end
  endtask

  initial begin
    pif.pkt_ready = 1'b0;
    pif_s.pkt_ready = 1'b1;
    test_reset_and_latency();
    test_overflow();
    test_full_push_pop();
    test_channel_mask();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
